// File: rtl/param_regfile_pkg.sv
// Shared sizes and entry layout for the parameter register file.
// The optional PARAM_REGFILE_FWD_EN build is selected in param_regfile.sv.
package param_regfile_pkg;

   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned DEPTH   = 4096;
   localparam int unsigned INEX_W  = 32;
   localparam int unsigned STATE_W = 18;
   localparam int unsigned CNT_W   = 13;

   typedef struct packed {
      logic [INEX_W-1:0]  inex;
      logic [STATE_W-1:0] state;
   } entry_t;

   // True when addr names a currently valid entry.
   function automatic logic addr_valid(input logic [ADDR_W-1:0] addr,
                                       input logic [CNT_W-1:0]  cnt);
      return ({1'b0, addr} < cnt);
   endfunction

endpackage

// File: rtl/param_regfile_mem.sv
// Storage array: one registered read port, one whole-entry append write and
// two independent single-field random writes. The array itself is never reset.
module param_regfile_mem
   import param_regfile_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_seq_we,
   input  logic [ADDR_W-1:0]  i_seq_addr,
   input  entry_t             i_seq_data,
   input  logic               i_state_we,
   input  logic [ADDR_W-1:0]  i_state_addr,
   input  logic [STATE_W-1:0] i_state_data,
   input  logic               i_inex_we,
   input  logic [ADDR_W-1:0]  i_inex_addr,
   input  logic [INEX_W-1:0]  i_inex_data,
   input  logic               i_re,
   input  logic [ADDR_W-1:0]  i_raddr,
   output entry_t             o_rdata
);

   logic [INEX_W-1:0]  r_inex  [DEPTH];
   logic [STATE_W-1:0] r_state [DEPTH];
   entry_t             r_rdata;

   // Append address never aliases a random-write address, so the writes never collide.
   always_ff @(posedge clk) begin
      if (i_seq_we) begin
         r_inex[i_seq_addr]  <= i_seq_data.inex;
         r_state[i_seq_addr] <= i_seq_data.state;
      end
      if (i_state_we) begin
         r_state[i_state_addr] <= i_state_data;
      end
      if (i_inex_we) begin
         r_inex[i_inex_addr] <= i_inex_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata.inex  <= r_inex[i_raddr];
         r_rdata.state <= r_state[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/param_regfile.sv
// Append-style register file: count/read-pointer control, read arbitration and
// optional same-cycle write forwarding (define PARAM_REGFILE_FWD_EN to enable).
module param_regfile
   import param_regfile_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               re_seq,
   input  logic               re_ran,
   input  logic [ADDR_W-1:0]  r_addr,
   output logic               rd_valid_o,
   output logic [ADDR_W-1:0]  addr_o,
   output logic [INEX_W-1:0]  inex_data_o,
   output logic [STATE_W-1:0] state_data_o,
   output logic               rd_err_o,
   input  logic               seq_we,
   input  logic [INEX_W-1:0]  seq_w_inex,
   input  logic [STATE_W-1:0] seq_w_state,
   input  logic               ran_we_state,
   input  logic [ADDR_W-1:0]  ran_w_addr_state,
   input  logic [STATE_W-1:0] ran_w_state,
   input  logic               ran_we_inex,
   input  logic [ADDR_W-1:0]  ran_w_addr_inex,
   input  logic [INEX_W-1:0]  ran_w_inex,
   output logic [CNT_W-1:0]   count_o,
   output logic               full_o,
   output logic               empty_o,
   output logic               overflow_o
);

   logic [CNT_W-1:0]   r_count;
   logic [ADDR_W-1:0]  r_rd_ptr;
   logic               r_rd_valid;
   logic [ADDR_W-1:0]  r_ret_addr;
   logic               r_err;
   logic               r_ovf;
   logic               r_fwd_state;
   logic               r_fwd_inex;
   logic [STATE_W-1:0] r_fwd_state_val;
   logic [INEX_W-1:0]  r_fwd_inex_val;

   logic               w_full;
   logic               w_empty;
   logic               w_seq_wr;
   logic               w_state_wr;
   logic               w_inex_wr;
   logic               w_rd_seq;
   logic               w_rd_en;
   logic               w_ran_err;
   logic [ADDR_W-1:0]  w_rd_addr;
   logic [CNT_W-1:0]   w_ptr_inc;
   logic [ADDR_W-1:0]  w_ptr_next;
   logic               w_hit_state;
   logic               w_hit_inex;
   entry_t             w_seq_entry;
   entry_t             w_mem_rdata;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   // Reset overrides every same-cycle write.
   assign w_seq_wr   = seq_we & ~w_full & ~rst;
   assign w_state_wr = ran_we_state & addr_valid(ran_w_addr_state, r_count) & ~rst;
   assign w_inex_wr  = ran_we_inex & addr_valid(ran_w_addr_inex, r_count) & ~rst;

   assign w_rd_seq  = re_seq & ~re_ran & ~w_empty;
   assign w_rd_en   = re_ran | w_rd_seq;
   assign w_ran_err = ~addr_valid(r_addr, r_count);
   assign w_rd_addr = re_ran ? r_addr : r_rd_ptr;

   // Wrap is judged against the pre-write count.
   assign w_ptr_inc  = {1'b0, r_rd_ptr} + CNT_W'(1);
   assign w_ptr_next = (w_ptr_inc == r_count) ? '0 : w_ptr_inc[ADDR_W-1:0];

`ifdef PARAM_REGFILE_FWD_EN
   assign w_hit_state = w_state_wr & (ran_w_addr_state == w_rd_addr);
   assign w_hit_inex  = w_inex_wr & (ran_w_addr_inex == w_rd_addr);
`else
   assign w_hit_state = 1'b0;
   assign w_hit_inex  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count         <= '0;
         r_rd_ptr        <= '0;
         r_rd_valid      <= 1'b0;
         r_ret_addr      <= '0;
         r_err           <= 1'b0;
         r_ovf           <= 1'b0;
         r_fwd_state     <= 1'b0;
         r_fwd_inex      <= 1'b0;
         r_fwd_state_val <= '0;
         r_fwd_inex_val  <= '0;
      end else begin
         if (w_seq_wr) begin
            r_count <= r_count + CNT_W'(1);
         end
         if (seq_we && w_full) begin
            r_ovf <= 1'b1;
         end
         if (w_rd_seq) begin
            r_rd_ptr <= w_ptr_next;
         end
         r_rd_valid <= w_rd_en;
         if (w_rd_en) begin
            r_ret_addr      <= w_rd_addr;
            r_err           <= re_ran & w_ran_err;
            r_fwd_state     <= w_hit_state;
            r_fwd_inex      <= w_hit_inex;
            r_fwd_state_val <= ran_w_state;
            r_fwd_inex_val  <= ran_w_inex;
         end
      end
   end

   assign w_seq_entry.inex  = seq_w_inex;
   assign w_seq_entry.state = seq_w_state;

   param_regfile_mem u_mem (
      .clk          (clk),
      .rst          (rst),
      .i_seq_we     (w_seq_wr),
      .i_seq_addr   (r_count[ADDR_W-1:0]),
      .i_seq_data   (w_seq_entry),
      .i_state_we   (w_state_wr),
      .i_state_addr (ran_w_addr_state),
      .i_state_data (ran_w_state),
      .i_inex_we    (w_inex_wr),
      .i_inex_addr  (ran_w_addr_inex),
      .i_inex_data  (ran_w_inex),
      .i_re         (w_rd_en & ~rst),
      .i_raddr      (w_rd_addr),
      .o_rdata      (w_mem_rdata)
   );

   // Flags captured with the read keep the data outputs stable between reads.
   always_comb begin
      inex_data_o  = r_fwd_inex ? r_fwd_inex_val : w_mem_rdata.inex;
      state_data_o = r_fwd_state ? r_fwd_state_val : w_mem_rdata.state;
      if (r_err) begin
         inex_data_o  = '0;
         state_data_o = '0;
      end
   end

   assign rd_valid_o = r_rd_valid;
   assign addr_o     = r_ret_addr;
   assign rd_err_o   = r_err;
   assign count_o    = r_count;
   assign full_o     = w_full;
   assign empty_o    = w_empty;
   assign overflow_o = r_ovf;

endmodule

// File: tb/tb_param_regfile.sv
// Self-checking bench for param_regfile: directed scenarios plus random traffic
// against an array-based reference model (honours PARAM_REGFILE_FWD_EN).
module tb_param_regfile;
   import param_regfile_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               re_seq, re_ran;
   logic [ADDR_W-1:0]  r_addr;
   logic               rd_valid_o;
   logic [ADDR_W-1:0]  addr_o;
   logic [INEX_W-1:0]  inex_data_o;
   logic [STATE_W-1:0] state_data_o;
   logic               rd_err_o;
   logic               seq_we;
   logic [INEX_W-1:0]  seq_w_inex;
   logic [STATE_W-1:0] seq_w_state;
   logic               ran_we_state;
   logic [ADDR_W-1:0]  ran_w_addr_state;
   logic [STATE_W-1:0] ran_w_state;
   logic               ran_we_inex;
   logic [ADDR_W-1:0]  ran_w_addr_inex;
   logic [INEX_W-1:0]  ran_w_inex;
   logic [CNT_W-1:0]   count_o;
   logic               full_o, empty_o, overflow_o;

   always #5 clk = ~clk;

   param_regfile dut (
      .clk              (clk),
      .rst              (rst),
      .re_seq           (re_seq),
      .re_ran           (re_ran),
      .r_addr           (r_addr),
      .rd_valid_o       (rd_valid_o),
      .addr_o           (addr_o),
      .inex_data_o      (inex_data_o),
      .state_data_o     (state_data_o),
      .rd_err_o         (rd_err_o),
      .seq_we           (seq_we),
      .seq_w_inex       (seq_w_inex),
      .seq_w_state      (seq_w_state),
      .ran_we_state     (ran_we_state),
      .ran_w_addr_state (ran_w_addr_state),
      .ran_w_state      (ran_w_state),
      .ran_we_inex      (ran_we_inex),
      .ran_w_addr_inex  (ran_w_addr_inex),
      .ran_w_inex       (ran_w_inex),
      .count_o          (count_o),
      .full_o           (full_o),
      .empty_o          (empty_o),
      .overflow_o       (overflow_o)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: plain arrays and integers.
   logic [31:0] m_inex  [4096];
   logic [17:0] m_state [4096];
   int          m_count = 0;
   int          m_ptr   = 0;
   bit          m_ovf   = 1'b0;
   bit          e_valid = 1'b0;
   int          e_addr  = 0;
   logic [31:0] e_inex  = '0;
   logic [17:0] e_state = '0;
   bit          e_err   = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit rd;
      int ra;
      bit st_ok, in_ok;
      if (rst) begin
         m_count = 0; m_ptr = 0; m_ovf = 0;
         e_valid = 0; e_addr = 0; e_inex = 0; e_state = 0; e_err = 0;
         return;
      end
      st_ok = ran_we_state && (int'(ran_w_addr_state) < m_count);
      in_ok = ran_we_inex && (int'(ran_w_addr_inex) < m_count);
      rd = 0;
      ra = 0;
      if (re_ran) begin
         rd = 1; ra = int'(r_addr); e_err = (ra >= m_count);
      end else if (re_seq && m_count > 0) begin
         rd = 1; ra = m_ptr; e_err = 0;
         m_ptr = (m_ptr + 1 == m_count) ? 0 : m_ptr + 1;
      end
      e_valid = rd;
      if (rd) begin
         e_addr = ra;
         if (e_err) begin
            e_inex = 0; e_state = 0;
         end else begin
            e_inex  = m_inex[ra];
            e_state = m_state[ra];
`ifdef PARAM_REGFILE_FWD_EN
            if (st_ok && int'(ran_w_addr_state) == ra) e_state = ran_w_state;
            if (in_ok && int'(ran_w_addr_inex) == ra) e_inex = ran_w_inex;
`endif
         end
      end
      if (st_ok) m_state[ran_w_addr_state] = ran_w_state;
      if (in_ok) m_inex[ran_w_addr_inex] = ran_w_inex;
      if (seq_we) begin
         if (m_count < 4096) begin
            m_inex[m_count]  = seq_w_inex;
            m_state[m_count] = seq_w_state;
            m_count++;
         end else begin
            m_ovf = 1;
         end
      end
   endtask

   task automatic compare();
      chk("rd_valid", 64'(rd_valid_o), 64'(e_valid));
      chk("count", 64'(count_o), 64'(m_count));
      chk("full", 64'(full_o), 64'(m_count == 4096));
      chk("empty", 64'(empty_o), 64'(m_count == 0));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      chk("addr", 64'(addr_o), 64'(e_addr));
      chk("inex", 64'(inex_data_o), 64'(e_inex));
      chk("state", 64'(state_data_o), 64'(e_state));
      if (e_valid) chk("rd_err", 64'(rd_err_o), 64'(e_err));
   endtask

   // Inputs are stable here (driven at negedge); model then DUT advance one edge.
   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic clr();
      rst = 0; re_seq = 0; re_ran = 0; r_addr = '0;
      seq_we = 0; seq_w_inex = '0; seq_w_state = '0;
      ran_we_state = 0; ran_w_addr_state = '0; ran_w_state = '0;
      ran_we_inex = 0; ran_w_addr_inex = '0; ran_w_inex = '0;
   endtask

   function automatic logic [ADDR_W-1:0] pick_addr();
      int lim;
      lim = m_count + 4;
      if (lim > 4096) lim = 4096;
      return ADDR_W'($urandom_range(lim - 1, 0));
   endfunction

   task automatic rand_inputs(input bit allow_rst);
      rst              = allow_rst && ($urandom_range(199, 0) == 0);
      re_seq           = $urandom_range(1, 0) == 1;
      re_ran           = $urandom_range(9, 0) < 3;
      r_addr           = pick_addr();
      seq_we           = $urandom_range(9, 0) < 3;
      seq_w_inex       = $urandom;
      seq_w_state      = STATE_W'($urandom);
      ran_we_state     = $urandom_range(9, 0) < 4;
      ran_w_addr_state = ($urandom_range(3, 0) == 0) ? r_addr : pick_addr();
      ran_w_state      = STATE_W'($urandom);
      ran_we_inex      = $urandom_range(9, 0) < 4;
      ran_w_addr_inex  = ($urandom_range(3, 0) == 0) ? r_addr : pick_addr();
      ran_w_inex       = $urandom;
   endtask

   initial begin
      clr();
      rst = 1;
      cycle();
      cycle();
      clr();
      chk("lit_reset_count", 64'(count_o), 64'd0);
      chk("lit_reset_empty", 64'(empty_o), 64'd1);

      for (int i = 0; i < 3; i++) begin
         clr();
         seq_we      = 1;
         seq_w_inex  = 32'h11 * (i + 1);
         seq_w_state = STATE_W'(i + 1);
         cycle();
      end
      clr();
      chk("lit_count3", 64'(count_o), 64'd3);

      for (int k = 0; k < 4; k++) begin
         clr();
         re_seq = 1;
         cycle();
         chk("lit_seq_valid", 64'(rd_valid_o), 64'd1);
         chk("lit_seq_addr", 64'(addr_o), 64'(k % 3));
         chk("lit_seq_inex", 64'(inex_data_o), 64'(32'h11 * (k % 3 + 1)));
         chk("lit_seq_state", 64'(state_data_o), 64'(k % 3 + 1));
      end

      clr();
      re_ran = 1; r_addr = 12'd5;
      cycle();
      chk("lit_oor_valid", 64'(rd_valid_o), 64'd1);
      chk("lit_oor_err", 64'(rd_err_o), 64'd1);
      chk("lit_oor_inex", 64'(inex_data_o), 64'd0);
      chk("lit_oor_state", 64'(state_data_o), 64'd0);
      clr();
      ran_we_state = 1; ran_w_addr_state = 12'd5; ran_w_state = 18'd7;
      cycle();
      chk("lit_oor_wr_count", 64'(count_o), 64'd3);

      clr();
      ran_we_state = 1; ran_w_addr_state = 12'd1; ran_w_state = 18'h3FFFF;
      ran_we_inex = 1; ran_w_addr_inex = 12'd1; ran_w_inex = 32'hDEADBEEF;
      re_ran = 1; r_addr = 12'd1;
      cycle();
`ifdef PARAM_REGFILE_FWD_EN
      chk("lit_coll_inex", 64'(inex_data_o), 64'hDEADBEEF);
      chk("lit_coll_state", 64'(state_data_o), 64'h3FFFF);
`else
      chk("lit_coll_inex", 64'(inex_data_o), 64'h22);
      chk("lit_coll_state", 64'(state_data_o), 64'h2);
`endif
      clr();
      re_ran = 1; r_addr = 12'd1;
      cycle();
      chk("lit_after_inex", 64'(inex_data_o), 64'hDEADBEEF);
      chk("lit_after_state", 64'(state_data_o), 64'h3FFFF);

      // rd_ptr is 1 here; a combined read must not move it.
      clr();
      re_seq = 1; re_ran = 1; r_addr = 12'd2;
      cycle();
      chk("lit_prio_addr", 64'(addr_o), 64'd2);
      chk("lit_prio_inex", 64'(inex_data_o), 64'h33);
      clr();
      re_seq = 1;
      cycle();
      chk("lit_ptr_hold_addr", 64'(addr_o), 64'd1);
      chk("lit_ptr_hold_inex", 64'(inex_data_o), 64'hDEADBEEF);

      clr();
      rst = 1; seq_we = 1; seq_w_inex = 32'h5A5A5A5A; seq_w_state = 18'h1;
      cycle();
      chk("lit_rst_wr_count", 64'(count_o), 64'd0);
      clr();
      re_ran = 1; r_addr = 12'd0;
      cycle();
      chk("lit_rst_wr_err", 64'(rd_err_o), 64'd1);

      repeat (3000) begin
         rand_inputs(1'b1);
         cycle();
      end

      clr();
      rst = 1;
      cycle();
      for (int i = 0; i < 4096; i++) begin
         clr();
         seq_we      = 1;
         seq_w_inex  = $urandom;
         seq_w_state = STATE_W'($urandom);
         cycle();
      end
      clr();
      chk("lit_full", 64'(full_o), 64'd1);
      seq_we = 1;
      cycle();
      chk("lit_ovf_count", 64'(count_o), 64'd4096);
      chk("lit_ovf_flag", 64'(overflow_o), 64'd1);

      repeat (400) begin
         rand_inputs(1'b0);
         cycle();
      end

      clr();
      rst = 1;
      cycle();
      clr();
      chk("lit_final_count", 64'(count_o), 64'd0);
      chk("lit_final_empty", 64'(empty_o), 64'd1);
      chk("lit_final_ovf", 64'(overflow_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
